// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: sequencer for a four-unit MAXNET winner-take-all network.
// Loads the initial activations (negative values clamped to zero), then
// repeats MULT/UPDATE/CHECK until at most one activation remains nonzero,
// and reports the surviving index and value.
//
// Optional feature: define MAXNET_TIMEOUT_EN to stop a run that still has
// more than one nonzero activation once iter_count reaches MAX_ITER; the
// run then ends with timeout=1 and no valid winner. Without the macro the
// iteration count is unbounded, timeout is tied low and MAX_ITER is unused.
//
// Handshake with the processing units: en1 is a one-cycle strobe telling
// the units to capture their products of pu_a0..3; en2 is a one-cycle
// strobe during which pu_new0..3 must be valid, and they are loaded into
// pu_a0..3 on the rising edge that ends that cycle. No back-pressure exists.
module maxnet_ctrl #(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        a_in0,
    input  logic [4:0]        a_in1,
    input  logic [4:0]        a_in2,
    input  logic [4:0]        a_in3,
    input  logic [4:0]        pu_new0,
    input  logic [4:0]        pu_new1,
    input  logic [4:0]        pu_new2,
    input  logic [4:0]        pu_new3,
    output logic [4:0]        pu_a0,
    output logic [4:0]        pu_a1,
    output logic [4:0]        pu_a2,
    output logic [4:0]        pu_a3,
    output logic              en1,
    output logic              en2,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic [4:0]        result,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MULT   = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0] act     [4];
    logic [4:0] a_init  [4];
    logic [4:0] a_new   [4];
    logic [2:0] nz_count;
    logic [1:0] nz_idx;
    logic [4:0] nz_val;
    logic       hit_limit;
    logic       finish_run;

    assign a_init[0] = a_in0;
    assign a_init[1] = a_in1;
    assign a_init[2] = a_in2;
    assign a_init[3] = a_in3;
    assign a_new[0]  = pu_new0;
    assign a_new[1]  = pu_new1;
    assign a_new[2]  = pu_new2;
    assign a_new[3]  = pu_new3;

    assign pu_a0 = act[0];
    assign pu_a1 = act[1];
    assign pu_a2 = act[2];
    assign pu_a3 = act[3];

    // Count surviving activations; the last nonzero one is the winner candidate
    always_comb begin
        nz_count = '0;
        nz_idx   = '0;
        nz_val   = '0;
        for (int i = 0; i < 4; i++) begin
            if (act[i] != 5'd0) begin
                nz_count = nz_count + 3'd1;
                nz_idx   = 2'(i);
                nz_val   = act[i];
            end
        end
    end

`ifdef MAXNET_TIMEOUT_EN
    assign hit_limit = (nz_count > 3'd1) && (iter_count == ITER_W'(MAX_ITER));
`else
    assign hit_limit = 1'b0;
`endif

    assign finish_run = (nz_count <= 3'd1) || hit_limit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_MULT;
            S_MULT:   state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_CHECK;
            S_CHECK:  state_nxt = finish_run ? S_DONE : S_MULT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        en1  = (state == S_MULT);
        en2  = (state == S_UPDATE);
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath registers: activations, iteration count and run results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) act[i] <= '0;
            iter_count   <= '0;
            timeout      <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    for (int i = 0; i < 4; i++) begin
                        act[i] <= a_init[i][4] ? 5'd0 : a_init[i];
                    end
                    iter_count   <= '0;
                    timeout      <= 1'b0;
                    winner_valid <= 1'b0;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 4; i++) act[i] <= a_new[i];
                    if (iter_count != {ITER_W{1'b1}}) begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (finish_run) begin
                        if (nz_count == 3'd1) begin
                            winner       <= nz_idx;
                            result       <= nz_val;
                            winner_valid <= 1'b1;
                        end else begin
                            winner       <= '0;
                            result       <= '0;
                            winner_valid <= 1'b0;
                        end
                        timeout <= hit_limit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed bench for maxnet_ctrl. The processing units are replaced by
// directly driven pu_new values chosen per scenario.
module tb_maxnet_ctrl;

    localparam int ITER_W = 4;
`ifdef MAXNET_TIMEOUT_EN
    localparam int MAX_ITER = 2;
`else
    localparam int MAX_ITER = 15;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [4:0]        a_in0, a_in1, a_in2, a_in3;
    logic [4:0]        pu_new0, pu_new1, pu_new2, pu_new3;
    logic [4:0]        pu_a0, pu_a1, pu_a2, pu_a3;
    logic              en1, en2, busy, done;
    logic [1:0]        winner;
    logic              winner_valid;
    logic [4:0]        result;
    logic [ITER_W-1:0] iter_count;
    logic              timeout;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc;
    int en2_cnt;

    maxnet_ctrl #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_in0        (a_in0),
        .a_in1        (a_in1),
        .a_in2        (a_in2),
        .a_in3        (a_in3),
        .pu_new0      (pu_new0),
        .pu_new1      (pu_new1),
        .pu_new2      (pu_new2),
        .pu_new3      (pu_new3),
        .pu_a0        (pu_a0),
        .pu_a1        (pu_a1),
        .pu_a2        (pu_a2),
        .pu_a3        (pu_a3),
        .en1          (en1),
        .en2          (en2),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_valid (winner_valid),
        .result       (result),
        .iter_count   (iter_count),
        .timeout      (timeout)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic [4:0] v0, input logic [4:0] v1,
                         input logic [4:0] v2, input logic [4:0] v3);
        a_in0 = v0; a_in1 = v1; a_in2 = v2; a_in3 = v3;
    endtask

    task automatic set_new(input logic [4:0] v0, input logic [4:0] v1,
                           input logic [4:0] v2, input logic [4:0] v3);
        pu_new0 = v0; pu_new1 = v1; pu_new2 = v2; pu_new3 = v3;
    endtask

    // Pulse start for one cycle; returns with the DUT in LOAD
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tick until done is seen, counting cycles after LOAD
    task automatic run_to_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (done) break;
        end
        if (!done) check("done_within_budget", 8'(done), 8'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_a(0, 0, 0, 0);
        set_new(0, 0, 0, 0);
        repeat (2) tick();

        // Reset state
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_en1", 8'(en1), 8'd0);
        check("rst_en2", 8'(en2), 8'd0);
        check("rst_pu_a0", 8'(pu_a0), 8'd0);
        check("rst_iter", 8'(iter_count), 8'd0);
        check("rst_wv", 8'(winner_valid), 8'd0);
        check("rst_timeout", 8'(timeout), 8'd0);
        rst = 1'b0;
        tick();

        // Single winner, cycle by cycle
        set_a(5'd8, 0, 0, 0);
        set_new(5'd8, 0, 0, 0);
        pulse_start();
        check("t1_load_busy", 8'(busy), 8'd1);
        check("t1_load_en1", 8'(en1), 8'd0);
        tick();
        check("t1_mult_en1", 8'(en1), 8'd1);
        check("t1_mult_pu_a0", 8'(pu_a0), 8'd8);
        tick();
        check("t1_upd_en2", 8'(en2), 8'd1);
        check("t1_upd_en1", 8'(en1), 8'd0);
        tick();
        check("t1_chk_iter", 8'(iter_count), 8'd1);
        check("t1_chk_en2", 8'(en2), 8'd0);
        check("t1_chk_done", 8'(done), 8'd0);
        tick();
        check("t1_done", 8'(done), 8'd1);
        check("t1_wv", 8'(winner_valid), 8'd1);
        check("t1_winner", 8'(winner), 8'd0);
        check("t1_result", 8'(result), 8'd8);
        tick();
        check("t1_idle_done", 8'(done), 8'd0);
        check("t1_idle_busy", 8'(busy), 8'd0);
        check("t1_hold_result", 8'(result), 8'd8);
        check("t1_hold_iter", 8'(iter_count), 8'd1);

        // All zero
        set_a(0, 0, 0, 0);
        set_new(0, 0, 0, 0);
        pulse_start();
        run_to_done(20, cyc);
        check("t2_cycles", 8'(cyc), 8'd4);
        check("t2_wv", 8'(winner_valid), 8'd0);
        check("t2_result", 8'(result), 8'd0);
        check("t2_winner", 8'(winner), 8'd0);
        check("t2_iter", 8'(iter_count), 8'd1);
        tick();

        // Negative clamp
        set_a(5'b11000, 0, 5'd4, 0);
        set_new(0, 0, 5'd4, 0);
        pulse_start();
        tick();
        check("t3_pu_a0_clamped", 8'(pu_a0), 8'd0);
        check("t3_pu_a2", 8'(pu_a2), 8'd4);
        run_to_done(20, cyc);
        check("t3_cycles", 8'(cyc), 8'd3);
        check("t3_winner", 8'(winner), 8'd2);
        check("t3_wv", 8'(winner_valid), 8'd1);
        check("t3_result", 8'(result), 8'd4);
        tick();

        // Start pulsed during MULT is ignored
        set_a(0, 0, 0, 5'd3);
        set_new(0, 0, 0, 5'd3);
        pulse_start();
        tick();
        check("t4_mult_en1", 8'(en1), 8'd1);
        check("t4_load_cleared_wv", 8'(winner_valid), 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_upd_en2", 8'(en2), 8'd1);
        tick();
        check("t4_chk_iter", 8'(iter_count), 8'd1);
        tick();
        check("t4_done", 8'(done), 8'd1);
        check("t4_winner", 8'(winner), 8'd3);
        check("t4_result", 8'(result), 8'd3);
        tick();
        check("t4_idle_busy", 8'(busy), 8'd0);
        tick();
        check("t4_no_relaunch", 8'(busy), 8'd0);

        // Reset during UPDATE
        set_a(5'd8, 0, 0, 0);
        set_new(5'd8, 0, 0, 0);
        pulse_start();
        tick();
        tick();
        check("t5_upd_en2", 8'(en2), 8'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", 8'(busy), 8'd0);
        check("t5_rst_en2", 8'(en2), 8'd0);
        check("t5_rst_pu_a0", 8'(pu_a0), 8'd0);
        check("t5_rst_result", 8'(result), 8'd0);
        check("t5_rst_winner", 8'(winner), 8'd0);
        check("t5_rst_wv", 8'(winner_valid), 8'd0);
        check("t5_rst_iter", 8'(iter_count), 8'd0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        run_to_done(20, cyc);
        check("t5_after_cycles", 8'(cyc), 8'd4);
        check("t5_after_winner", 8'(winner), 8'd0);
        check("t5_after_result", 8'(result), 8'd8);
        check("t5_after_wv", 8'(winner_valid), 8'd1);
        check("t5_after_iter", 8'(iter_count), 8'd1);
        tick();

        // Long run: two survivors until the 18th update (or the timeout)
        set_a(5'd8, 5'd8, 0, 0);
        set_new(5'd8, 5'd8, 0, 0);
        en2_cnt = 0;
        cyc = 0;
        pulse_start();
        while (cyc < 200) begin
            tick();
            cyc++;
            if (en2) begin
                en2_cnt++;
                if (en2_cnt == 18) set_new(0, 5'd3, 0, 0);
            end
            if (done) break;
        end
        check("t6_done_seen", 8'(done), 8'd1);
`ifdef MAXNET_TIMEOUT_EN
        check("t6_updates", 8'(en2_cnt), 8'd2);
        check("t6_cycles", 8'(cyc), 8'd7);
        check("t6_iter", 8'(iter_count), 8'd2);
        check("t6_timeout", 8'(timeout), 8'd1);
        check("t6_wv", 8'(winner_valid), 8'd0);
        check("t6_result", 8'(result), 8'd0);
`else
        check("t6_updates", 8'(en2_cnt), 8'd18);
        check("t6_cycles", 8'(cyc), 8'd55);
        check("t6_iter_saturated", 8'(iter_count), 8'd15);
        check("t6_timeout", 8'(timeout), 8'd0);
        check("t6_wv", 8'(winner_valid), 8'd1);
        check("t6_winner", 8'(winner), 8'd1);
        check("t6_result", 8'(result), 8'd3);
`endif
        tick();
        check("t6_idle_busy", 8'(busy), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
